// File: rtl/popcount_enumerator_if.sv
// Request/response bundle for popcount_enumerator: command channel in, word stream out.
// The enumerator sits on the slave side and the requester/consumer sits on the master side.
interface popcount_enumerator_if #(
  parameter int W  = 7,
  parameter int KW = 3
) ();
  logic          cmd_vld;
  logic [KW-1:0] cmd_k;
  logic          cmd_rdy;
  logic          out_vld;
  logic [W-1:0]  out_w;
  logic          out_rdy;
  logic          out_last;
  logic          err;
  logic [W:0]    out_cnt;

  modport master (
    output cmd_vld, cmd_k, out_rdy,
    input  cmd_rdy, out_vld, out_w, out_last, err, out_cnt
  );

  modport slave (
    input  cmd_vld, cmd_k, out_rdy,
    output cmd_rdy, out_vld, out_w, out_last, err, out_cnt
  );
endinterface

// File: rtl/popcount_enumerator.sv
// Emits every W-bit word with popcount k in ascending order by scanning candidates
// 0..2^W-1 and presenting those whose compressed popcount matches k.
module popcount_enumerator #(
  parameter int W  = 7,
  parameter int KW = 3   // must equal $clog2(W+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  popcount_enumerator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  c_q, c_d;
  logic [KW-1:0] k_q, k_d;
  logic [W:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [KW-1:0] pc;
  logic          match;
  logic          is_last;
  logic [W:0]    ones;
  logic [W-1:0]  last_word;

  // Popcount of the current candidate.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  generate
    if (W == 7) begin : g_fa_tree
      // Four full adders: two compress bits 0..5, one folds bit 6 into the
      // weight-1 column, one reduces the three weight-2 carries.
      logic [1:0] f0, f1, f2, f3;
      assign f0 = fa(c_q[0], c_q[1], c_q[2]);
      assign f1 = fa(c_q[3], c_q[4], c_q[5]);
      assign f2 = fa(c_q[6], f0[0], f1[0]);
      assign f3 = fa(f0[1], f1[1], f2[1]);
      assign pc = KW'({f3[1], f3[0], f2[0]});
    end else begin : g_generic
      always_comb begin
        pc = '0;
        for (int i = 0; i < W; i++) pc = pc + KW'(c_q[i]);
      end
    end
  endgenerate

  // Highest word with popcount k: k ones packed against the MSB.
  assign ones      = ((W+1)'(1) << k_q) - (W+1)'(1);
  assign last_word = ones[W-1:0] << (W - int'(k_q));

  assign match   = (state_q == SCAN) && (pc == k_q);
  assign is_last = match && (c_q == last_word);

  assign bus.cmd_rdy  = (state_q == IDLE);
  assign bus.out_vld  = match;
  assign bus.out_w    = c_q;
  assign bus.out_last = is_last;
  assign bus.err      = err_q;
  assign bus.out_cnt  = cnt_q;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    c_d     = c_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_vld) begin
          if (32'(bus.cmd_k) > W) begin
            err_d = 1'b1;
          end else begin
            k_d     = bus.cmd_k;
            c_d     = '0;
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (!match) begin
          c_d = c_q + W'(1);
        end else if (bus.out_rdy) begin
          cnt_d = cnt_q + (W+1)'(1);
          // The last match is the final candidate, so c never wraps past 2^W-1.
          if (is_last) state_d = FIN;
          else         c_d     = c_q + W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_popcount_enumerator.sv
// Directed bench for popcount_enumerator: a table of full enumerations plus
// hand-written sequences for error rejection and reset abort.
module tb_popcount_enumerator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  popcount_enumerator_if #(.W(7), .KW(3)) bus  ();
  popcount_enumerator_if #(.W(6), .KW(3)) bus6 ();

  popcount_enumerator #(.W(7), .KW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Narrower instance: a 3-bit k can exceed W only when W < 7.
  popcount_enumerator #(.W(6), .KW(3)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  typedef struct {
    int k;
    bit stall;
    int n;
    int first;
    int last;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int pop7(input logic [6:0] v);
    int n = 0;
    for (int i = 0; i < 7; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic run_enum(input int k, input bit stall, input int exp_n,
                          input int exp_first, input int exp_last);
    int cyc, n, first_w, prev_w, last_cyc, bad_pop, bad_order, bad_hold, held_w;
    bit done, held, rdy;
    n = 0; first_w = -1; prev_w = -1; last_cyc = -1;
    bad_pop = 0; bad_order = 0; bad_hold = 0; held_w = 0;
    done = 1'b0; held = 1'b0;

    @(negedge clk);
    check($sformatf("k%0d cmd_rdy before request", k), 32'(bus.cmd_rdy), 32'd1);
    bus.cmd_vld = 1'b1;
    bus.cmd_k   = 3'(k);
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    bus.cmd_vld = 1'b0;

    while (!done && cyc < 2000) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_rdy = rdy;
      if (held && !(bus.out_vld && int'(bus.out_w) == held_w)) bad_hold++;
      held = 1'b0;
      if (bus.out_vld) begin
        if (rdy) begin
          if (pop7(bus.out_w) != k) bad_pop++;
          if (int'(bus.out_w) <= prev_w) bad_order++;
          if (n == 0) first_w = int'(bus.out_w);
          prev_w = int'(bus.out_w);
          n++;
          if (bus.out_last) begin
            done     = 1'b1;
            last_cyc = cyc + 1;
          end
        end else begin
          held   = 1'b1;
          held_w = int'(bus.out_w);
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    bus.out_rdy = 1'b0;

    check($sformatf("k%0d out_last reached", k), 32'(done), 32'd1);
    check($sformatf("k%0d word count", k), 32'(n), 32'(exp_n));
    check($sformatf("k%0d first word", k), 32'(first_w), 32'(exp_first));
    check($sformatf("k%0d final word", k), 32'(prev_w), 32'(exp_last));
    check($sformatf("k%0d popcount errors", k), 32'(bad_pop), 32'd0);
    check($sformatf("k%0d order errors", k), 32'(bad_order), 32'd0);
    if (stall) check($sformatf("k%0d stall stability errors", k), 32'(bad_hold), 32'd0);
    else       check($sformatf("k%0d last word latency", k), 32'(last_cyc), 32'(exp_last + 1));
    check($sformatf("k%0d cmd_rdy in FIN", k), 32'(bus.cmd_rdy), 32'd0);
    check($sformatf("k%0d out_vld in FIN", k), 32'(bus.out_vld), 32'd0);
    @(negedge clk);
    check($sformatf("k%0d cmd_rdy after FIN", k), 32'(bus.cmd_rdy), 32'd1);
    check($sformatf("k%0d out_cnt held", k), 32'(bus.out_cnt), 32'(exp_n));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   exp4[10];
    int   n, cyc;

    vecs[0] = '{k: 0, stall: 1'b0, n: 1,  first: 'h00, last: 'h00};
    vecs[1] = '{k: 1, stall: 1'b0, n: 7,  first: 'h01, last: 'h40};
    vecs[2] = '{k: 2, stall: 1'b0, n: 21, first: 'h03, last: 'h60};
    vecs[3] = '{k: 3, stall: 1'b1, n: 35, first: 'h07, last: 'h70};
    vecs[4] = '{k: 3, stall: 1'b0, n: 35, first: 'h07, last: 'h70};
    vecs[5] = '{k: 4, stall: 1'b0, n: 35, first: 'h0F, last: 'h78};
    vecs[6] = '{k: 5, stall: 1'b1, n: 21, first: 'h1F, last: 'h7C};
    vecs[7] = '{k: 6, stall: 1'b0, n: 7,  first: 'h3F, last: 'h7E};
    vecs[8] = '{k: 7, stall: 1'b0, n: 1,  first: 'h7F, last: 'h7F};
    exp4 = '{'h0F, 'h17, 'h1B, 'h1D, 'h1E, 'h27, 'h2B, 'h2D, 'h2E, 'h33};

    rst = 1'b1;
    bus.cmd_vld  = 1'b0; bus.cmd_k  = '0; bus.out_rdy  = 1'b0;
    bus6.cmd_vld = 1'b0; bus6.cmd_k = '0; bus6.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset cmd_rdy",  32'(bus.cmd_rdy),  32'd1);
    check("reset out_vld",  32'(bus.out_vld),  32'd0);
    check("reset out_last", 32'(bus.out_last), 32'd0);
    check("reset err",      32'(bus.err),      32'd0);
    check("reset out_cnt",  32'(bus.out_cnt),  32'd0);

    for (int i = 0; i < 9; i++)
      run_enum(vecs[i].k, vecs[i].stall, vecs[i].n, vecs[i].first, vecs[i].last);

    // W=6 instance: one legal request, then an out-of-range k.
    @(negedge clk);
    bus6.cmd_vld = 1'b1;
    bus6.cmd_k   = 3'd6;
    @(posedge clk);
    @(negedge clk);
    bus6.cmd_vld = 1'b0;
    bus6.out_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus6.out_vld) break;
      @(negedge clk);
    end
    check("w6 k6 word",     32'(bus6.out_w),    32'h3F);
    check("w6 k6 out_last", 32'(bus6.out_last), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("w6 k6 out_cnt", 32'(bus6.out_cnt), 32'd1);
    bus6.cmd_vld = 1'b1;
    bus6.cmd_k   = 3'd7;
    @(negedge clk);
    bus6.cmd_vld = 1'b0;
    check("err pulse",           32'(bus6.err),     32'd1);
    check("err cmd_rdy",         32'(bus6.cmd_rdy), 32'd1);
    check("err out_vld",         32'(bus6.out_vld), 32'd0);
    @(negedge clk);
    check("err pulse ends",      32'(bus6.err),     32'd0);
    check("err out_vld later",   32'(bus6.out_vld), 32'd0);
    check("err out_cnt kept",    32'(bus6.out_cnt), 32'd1);
    check("err cmd_rdy later",   32'(bus6.cmd_rdy), 32'd1);

    // k=4, stray command mid-scan, reset after the 10th transfer.
    @(negedge clk);
    bus.cmd_vld = 1'b1;
    bus.cmd_k   = 3'd4;
    bus.out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    n = 0;
    for (cyc = 0; n < 10 && cyc < 500; cyc++) begin
      if (cyc == 3) begin
        bus.cmd_vld = 1'b1;
        bus.cmd_k   = 3'd1;
      end else begin
        bus.cmd_vld = 1'b0;
      end
      if (bus.out_vld) begin
        check($sformatf("abort run word %0d", n), 32'(bus.out_w), 32'(exp4[n]));
        n++;
      end
      @(negedge clk);
    end
    bus.cmd_vld = 1'b0;
    check("abort run out_cnt before reset", 32'(bus.out_cnt), 32'd10);
    bus.out_rdy = 1'b0;
    bus.cmd_vld = 1'b1;
    bus.cmd_k   = 3'd2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.cmd_vld = 1'b0;
    check("after abort out_vld",  32'(bus.out_vld),  32'd0);
    check("after abort out_last", 32'(bus.out_last), 32'd0);
    check("after abort cmd_rdy",  32'(bus.cmd_rdy),  32'd1);
    check("after abort out_cnt",  32'(bus.out_cnt),  32'd0);
    run_enum(2, 1'b0, 21, 'h03, 'h60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
